// File: rtl/spike_count_decoder.sv
// Purpose: per-class spike counting over one inference window, then sequential argmax.
// Latency: result/done arrive NUM_CLASSES edges after the last accepted timestep beat.
// Backpressure: none; spike_valid beats are taken whenever counting, ignored otherwise.
module spike_count_decoder #(
    parameter int NUM_CLASSES  = 10,
    parameter int TIMESTEP_MAX = 200,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   spike_valid,
    input  logic [NUM_CLASSES-1:0] spike_in,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             result,
    output logic                   result_valid,
    output logic                   no_spike
);
    localparam int TSW  = $clog2(TIMESTEP_MAX + 1);
    localparam int IDXW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [TSW-1:0]       TS_ONE   = 1;
    localparam logic [TSW-1:0]       TS_LAST  = TSW'(TIMESTEP_MAX - 1);
    localparam logic [IDXW-1:0]      IDX_ONE  = 1;
    localparam logic [IDXW-1:0]      IDX_LAST = IDXW'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ARGMAX = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0] cnt [NUM_CLASSES];
    logic [TSW-1:0]       ts_cnt;
    logic [IDXW-1:0]      idx;
    logic [IDXW-1:0]      best_idx;
    logic [CNT_WIDTH-1:0] best_cnt;

    logic                 last_beat;
    logic                 last_scan;
    logic                 take;
    logic [IDXW-1:0]      fin_idx;
    logic [CNT_WIDTH-1:0] fin_cnt;

    always_comb begin
        last_beat = (state == COUNT) && spike_valid && (ts_cnt == TS_LAST);
        last_scan = (state == ARGMAX) && (idx == IDX_LAST);
        // Strict compare so ties keep the lower index already held in best_idx.
        take      = (idx == '0) || (cnt[idx] > best_cnt);
        fin_idx   = take ? idx : best_idx;
        fin_cnt   = take ? cnt[idx] : best_cnt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = COUNT;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                COUNT:   if (last_beat) state_nxt = ARGMAX;
                ARGMAX:  if (last_scan) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            ts_cnt       <= '0;
            idx          <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            done         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            no_spike     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
                ts_cnt       <= '0;
                result_valid <= 1'b0;
                no_spike     <= 1'b0;
            end else if (state == COUNT && spike_valid) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (spike_in[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
                end
                ts_cnt <= ts_cnt + TS_ONE;
                if (last_beat) begin
                    idx      <= '0;
                    best_idx <= '0;
                    best_cnt <= '0;
                end
            end else if (state == ARGMAX) begin
                best_idx <= fin_idx;
                best_cnt <= fin_cnt;
                idx      <= idx + IDX_ONE;
                if (last_scan) begin
                    result       <= 4'(fin_idx);
                    no_spike     <= (fin_cnt == '0);
                    result_valid <= 1'b1;
                    done         <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_count_decoder.sv
// Scoreboard bench: two decoders (8-bit and 6-bit counters) share stimulus; a count
// model predicts each window's argmax, queued at the last beat and popped on done.
module tb_spike_count_decoder;
    logic       clk = 1'b0;
    logic       rstn, start, spike_valid;
    logic [9:0] spike_in;
    logic       busy, done, result_valid, no_spike;
    logic [3:0] result;
    logic       busy6, done6, rv6, ns6;
    logic [3:0] res6;

    always #5 clk = ~clk;

    spike_count_decoder dut (
        .clk(clk), .rstn(rstn), .start(start), .spike_valid(spike_valid),
        .spike_in(spike_in), .busy(busy), .done(done), .result(result),
        .result_valid(result_valid), .no_spike(no_spike)
    );

    spike_count_decoder #(.CNT_WIDTH(6)) dut6 (
        .clk(clk), .rstn(rstn), .start(start), .spike_valid(spike_valid),
        .spike_in(spike_in), .busy(busy6), .done(done6), .result(res6),
        .result_valid(rv6), .no_spike(ns6)
    );

    typedef struct packed {
        logic [3:0] res;
        logic       ns;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   m8 [10];
    int   m6 [10];
    exp_t q8 [$];
    exp_t q6 [$];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic exp_t argmax(input int m [10]);
        exp_t e;
        int   best;
        e.res = 4'd0;
        best  = m[0];
        for (int i = 1; i < 10; i++) begin
            if (m[i] > best) begin
                best  = m[i];
                e.res = 4'(i);
            end
        end
        e.ns = (best == 0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            m8[i] = 0;
            m6[i] = 0;
        end
    endtask

    task automatic beat(input logic [9:0] s);
        spike_valid = 1'b1;
        spike_in    = s;
        for (int i = 0; i < 10; i++) begin
            if (s[i]) begin
                if (m8[i] < 255) m8[i]++;
                if (m6[i] < 63)  m6[i]++;
            end
        end
        step();
        spike_valid = 1'b0;
        spike_in    = 10'($urandom);
    endtask

    task automatic push_exp();
        q8.push_back(argmax(m8));
        q6.push_back(argmax(m6));
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            start       = c[0];
            spike_valid = ~c[0];
            spike_in    = 10'h3FF;
            step();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", result_valid); end
        checks++; if (no_spike !== 1'b0) begin errors++; $display("FAIL reset_ns: got %b want 0", no_spike); end
        checks++; if (result !== 4'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++; if (busy6 !== 1'b0 || rv6 !== 1'b0) begin errors++; $display("FAIL reset_dut6: got busy=%b rv=%b want 0 0", busy6, rv6); end
        start = 1'b0; spike_valid = 1'b0; spike_in = '0;
        rstn = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_nominal();
        int   lat;
        exp_t e8, e6;
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b want 1", busy); end
        for (int b = 0; b < 200; b++) beat(10'h080 | ((b % 2 == 0) ? 10'h37F : 10'h000));
        push_exp();
        wait_done(lat);
        e8 = q8.pop_front(); e6 = q6.pop_front();
        checks++; if (lat !== 10) begin errors++; $display("FAIL nom_latency: got %0d want 10", lat); end
        checks++; if (result !== e8.res) begin errors++; $display("FAIL nom_result: got %0d want %0d", result, e8.res); end
        checks++; if (no_spike !== e8.ns) begin errors++; $display("FAIL nom_ns: got %b want %b", no_spike, e8.ns); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL nom_rv: got %b want 1", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_end: got %b want 0", busy); end
        checks++; if (res6 !== e6.res || ns6 !== e6.ns) begin errors++; $display("FAIL nom_dut6: got %0d/%b want %0d/%b", res6, ns6, e6.res, e6.ns); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nom_done_clear: got %b want 0", done); end
        checks++; if (result !== e8.res || result_valid !== 1'b1) begin errors++; $display("FAIL nom_hold: got %0d/%b want %0d/1", result, result_valid, e8.res); end
    endtask

    task automatic test_tie();
        int   lat;
        exp_t e8, e6;
        do_start();
        for (int b = 0; b < 200; b++) beat(((b < 50) ? 10'h028 : 10'h000) | ((b < 20) ? 10'h3D7 : 10'h000));
        push_exp();
        wait_done(lat);
        e8 = q8.pop_front(); e6 = q6.pop_front();
        checks++; if (lat !== 10) begin errors++; $display("FAIL tie_latency: got %0d want 10", lat); end
        checks++; if (result !== e8.res) begin errors++; $display("FAIL tie_result: got %0d want %0d", result, e8.res); end
        checks++; if (res6 !== e6.res) begin errors++; $display("FAIL tie_dut6: got %0d want %0d", res6, e6.res); end
        step();
    endtask

    task automatic test_silent();
        int   lat;
        exp_t e8, e6;
        do_start();
        for (int b = 0; b < 200; b++) beat(10'h000);
        push_exp();
        wait_done(lat);
        e8 = q8.pop_front(); e6 = q6.pop_front();
        checks++; if (result !== e8.res) begin errors++; $display("FAIL silent_result: got %0d want %0d", result, e8.res); end
        checks++; if (no_spike !== e8.ns) begin errors++; $display("FAIL silent_ns: got %b want %b", no_spike, e8.ns); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL silent_rv: got %b want 1", result_valid); end
        checks++; if (ns6 !== e6.ns) begin errors++; $display("FAIL silent_dut6_ns: got %b want %b", ns6, e6.ns); end
        step();
    endtask

    task automatic test_saturation();
        int   lat;
        exp_t e8, e6;
        do_start();
        for (int b = 0; b < 200; b++) beat(10'h200 | ((b < 63) ? 10'h002 : 10'h000));
        push_exp();
        wait_done(lat);
        e8 = q8.pop_front(); e6 = q6.pop_front();
        checks++; if (res6 !== e6.res) begin errors++; $display("FAIL sat_dut6_result: got %0d want %0d", res6, e6.res); end
        checks++; if (ns6 !== e6.ns) begin errors++; $display("FAIL sat_dut6_ns: got %b want %b", ns6, e6.ns); end
        checks++; if (result !== e8.res) begin errors++; $display("FAIL sat_dut8_result: got %0d want %0d", result, e8.res); end
        step();
    endtask

    task automatic test_abort_gaps();
        int   lat, base;
        exp_t e8;
        base = done_cnt;
        do_start();
        for (int b = 0; b < 100; b++) beat(10'h001);
        do_start();
        checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b rv=%b want 1 0", busy, result_valid); end
        for (int b = 0; b < 200; b++) begin
            if ($urandom_range(0, 3) == 0) step();
            beat(10'h010);
        end
        push_exp();
        wait_done(lat);
        e8 = q8.pop_front(); void'(q6.pop_front());
        checks++; if (lat !== 10) begin errors++; $display("FAIL abort_latency: got %0d want 10", lat); end
        checks++; if (result !== e8.res) begin errors++; $display("FAIL abort_result: got %0d want %0d", result, e8.res); end
        step();
        checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL abort_done_pulses: got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_abort_scan();
        int   lat, base;
        exp_t e8;
        do_start();
        for (int b = 0; b < 200; b++) beat(10'h004);
        step(); step(); step();
        base = done_cnt;
        do_start();
        checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL scan_abort_state: got busy=%b rv=%b want 1 0", busy, result_valid); end
        for (int c = 0; c < 15; c++) step();
        checks++; if (done_cnt - base !== 0 || busy !== 1'b1) begin errors++; $display("FAIL scan_abort_quiet: got pulses=%0d busy=%b want 0 1", done_cnt - base, busy); end
        for (int b = 0; b < 200; b++) beat(10'h200);
        push_exp();
        wait_done(lat);
        e8 = q8.pop_front(); void'(q6.pop_front());
        checks++; if (result !== e8.res) begin errors++; $display("FAIL scan_abort_result: got %0d want %0d", result, e8.res); end
        step();
    endtask

    initial begin
        start = 1'b0; spike_valid = 1'b0; spike_in = '0; rstn = 1'b0;
        for (int i = 0; i < 10; i++) begin m8[i] = 0; m6[i] = 0; end
        test_reset();
        test_nominal();
        test_tie();
        test_silent();
        test_saturation();
        test_abort_gaps();
        test_abort_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
